bsg_mul_iterative_mac: RTL

//  Parametrised iterative multiply-accumulate unit: result = A*B + C, computed modulo 2^(2*width_p).
//  A and B each carry a per-operation signed/unsigned flag; C is a two's-complement 2*width_p addend.

---
 rtl/bsg_mul_iterative_mac_if.sv | 28 ++
 rtl/bsg_mul_iterative_mac.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bsg_mul_iterative_mac_if.sv
// Operation/result channel of the iterative MAC: valid/ready request side, valid/yumi result side.
interface bsg_mul_iterative_mac_if #(
    parameter int unsigned width_p     = 32,
    parameter int unsigned tag_width_p = 4
);
    logic                     v_i;
    logic                     ready_o;
    logic [width_p-1:0]       opA_i;
    logic                     opA_is_signed_i;
    logic [width_p-1:0]       opB_i;
    logic                     opB_is_signed_i;
    logic [2*width_p-1:0]     opC_i;
    logic [tag_width_p-1:0]   tag_i;
    logic                     v_o;
    logic [2*width_p-1:0]     result_o;
    logic [tag_width_p-1:0]   tag_o;
    logic                     yumi_i;

    modport master (
        output v_i, opA_i, opA_is_signed_i, opB_i, opB_is_signed_i, opC_i, tag_i, yumi_i,
        input  ready_o, v_o, result_o, tag_o
    );

    modport slave (
        input  v_i, opA_i, opA_is_signed_i, opB_i, opB_is_signed_i, opC_i, tag_i, yumi_i,
        output ready_o, v_o, result_o, tag_o
    );
endinterface

// File: rtl/bsg_mul_iterative_mac.sv
// Iterative sign-magnitude multiply-accumulate: result = A*B + C mod 2^(2*width_p),
// retiring iter_step_p multiplier bits per cycle with optional early termination.
module bsg_mul_iterative_mac #(
    parameter int unsigned width_p      = 32,
    parameter int unsigned iter_step_p  = 8,
    parameter int unsigned tag_width_p  = 4,
    parameter int unsigned early_term_p = 1
) (
    input  logic clk_i,
    input  logic reset_n_i,
    bsg_mul_iterative_mac_if.slave mac_if
);

    localparam int unsigned prod_w_lp = 2 * width_p;
    localparam int unsigned steps_lp  = width_p / iter_step_p;
    localparam int unsigned cnt_w_lp  = $clog2(steps_lp + 1);
    localparam int unsigned sh_w_lp   = $clog2(prod_w_lp);

    if ((iter_step_p == 0) || (iter_step_p > width_p) || ((width_p % iter_step_p) != 0)) begin : g_bad_params
        $error("bsg_mul_iterative_mac: width_p must be a non-zero multiple of iter_step_p");
    end

    typedef enum logic [1:0] {eIDLE, eCALC, eFIX, eDONE} state_e;

    state_e                 state_q, state_d;
    logic [width_p-1:0]     a_mag_q, a_mag_d;
    logic [width_p-1:0]     b_mag_q, b_mag_d;
    logic                   neg_q, neg_d;
    logic [prod_w_lp-1:0]   c_q, c_d;
    logic [tag_width_p-1:0] tag_q, tag_d;
    logic [prod_w_lp-1:0]   prod_q, prod_d;
    logic [cnt_w_lp-1:0]    digit_q, digit_d;
    logic [prod_w_lp-1:0]   result_q, result_d;
    logic [tag_width_p-1:0] tag_out_q, tag_out_d;
    logic                   v_q, v_d;
    logic                   ready_q, ready_d;

    logic                   a_neg_c, b_neg_c, last_calc_c;
    logic [prod_w_lp-1:0]   partial_c, fixed_c;
    logic [sh_w_lp-1:0]     shamt_c;

    // Next-state and datapath
    always_comb begin
        state_d   = state_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        neg_d     = neg_q;
        c_d       = c_q;
        tag_d     = tag_q;
        prod_d    = prod_q;
        digit_d   = digit_q;
        result_d  = result_q;
        tag_out_d = tag_out_q;

        a_neg_c   = mac_if.opA_is_signed_i & mac_if.opA_i[width_p-1];
        b_neg_c   = mac_if.opB_is_signed_i & mac_if.opB_i[width_p-1];
        partial_c = prod_w_lp'(a_mag_q) * prod_w_lp'(b_mag_q[iter_step_p-1:0]);
        shamt_c   = sh_w_lp'(digit_q) * sh_w_lp'(iter_step_p);
        fixed_c   = neg_q ? (-prod_q) : prod_q;

        // A check cycle after each retired digit decides whether any multiplier bits remain
        last_calc_c = (digit_q != '0)
                   && ((digit_q == cnt_w_lp'(steps_lp))
                       || ((early_term_p != 0) && (b_mag_q == '0)));

        unique case (state_q)
            eIDLE: begin
                if (mac_if.v_i) begin
                    state_d = eCALC;
                    a_mag_d = a_neg_c ? (-mac_if.opA_i) : mac_if.opA_i;
                    b_mag_d = b_neg_c ? (-mac_if.opB_i) : mac_if.opB_i;
                    neg_d   = a_neg_c ^ b_neg_c;
                    c_d     = mac_if.opC_i;
                    tag_d   = mac_if.tag_i;
                    prod_d  = '0;
                    digit_d = '0;
                end
            end
            eCALC: begin
                if (last_calc_c) begin
                    state_d = eFIX;
                end else begin
                    prod_d  = prod_q + (partial_c << shamt_c);
                    b_mag_d = b_mag_q >> iter_step_p;
                    digit_d = digit_q + cnt_w_lp'(1);
                end
            end
            eFIX: begin
                result_d  = fixed_c + c_q;
                tag_out_d = tag_q;
                state_d   = eDONE;
            end
            eDONE: begin
                if (mac_if.yumi_i) begin
                    state_d = eIDLE;
                end
            end
            default: state_d = eIDLE;
        endcase

        v_d     = (state_d == eDONE);
        ready_d = (state_d == eIDLE);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= eIDLE;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            neg_q     <= 1'b0;
            c_q       <= '0;
            tag_q     <= '0;
            prod_q    <= '0;
            digit_q   <= '0;
            result_q  <= '0;
            tag_out_q <= '0;
            v_q       <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            neg_q     <= neg_d;
            c_q       <= c_d;
            tag_q     <= tag_d;
            prod_q    <= prod_d;
            digit_q   <= digit_d;
            result_q  <= result_d;
            tag_out_q <= tag_out_d;
            v_q       <= v_d;
            ready_q   <= ready_d;
        end
    end

    assign mac_if.ready_o  = ready_q;
    assign mac_if.v_o      = v_q;
    assign mac_if.result_o = result_q;
    assign mac_if.tag_o    = tag_out_q;

endmodule
